store_write_buffer: RTL and testbench

- Posted-write buffer between the pipeline's MEM-stage data-memory store port and a slow, handshaked data RAM.
- Stores retire from MEM in one cycle into a FIFO.
- An FSM drains the FIFO to RAM over a req/ack handshake.
- Loads in MEM receive the youngest buffered value for a matching word address, so read-after-write ordering is preserved without stalling.

---
 rtl/store_write_buffer_pkg.sv | 14 +
 rtl/store_write_buffer_if.sv | 42 ++++
 rtl/store_write_buffer_fwd_match.sv | 37 +++
 rtl/store_write_buffer.sv | 113 +++++++++++
 tb/tb_store_write_buffer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_write_buffer_pkg.sv
// Shared constants and FSM encoding for the store write buffer.
// Defaults match the data RAM word-address and data widths.
package store_write_buffer_pkg;

  localparam int SWB_DEPTH = 4;
  localparam int SWB_AW    = 6;
  localparam int SWB_DW    = 32;

  typedef enum logic {
    SWB_IDLE = 1'b0,
    SWB_REQ  = 1'b1
  } swb_state_e;

endpackage

// File: rtl/store_write_buffer_if.sv
// MEM-stage store/load ports, RAM write handshake and buffer status.
// slave is the buffer side, master is the pipeline/RAM side.
interface store_write_buffer_if
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH = SWB_DEPTH,
  parameter int AW    = SWB_AW,
  parameter int DW    = SWB_DW
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic [31:0]   st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic          ld_valid;
  logic [31:0]   ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          ram_req;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_ack;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          stall;

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, ram_ack,
    output st_ready, ld_hit, ld_data, ram_req, ram_addr, ram_wdata,
           count, full, empty, stall
  );

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, ram_ack,
    input  st_ready, ld_hit, ld_data, ram_req, ram_addr, ram_wdata,
           count, full, empty, stall
  );

endinterface

// File: rtl/store_write_buffer_fwd_match.sv
// Youngest-first address matcher over the buffered stores; purely combinational.
// No backpressure: result is valid in the same cycle as the load.
module swb_fwd_match
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH = SWB_DEPTH,
  parameter int AW    = SWB_AW,
  parameter int DW    = SWB_DW,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic                      i_ld_vld,
  input  logic [AW-1:0]             i_ld_addr,
  input  logic [PW-1:0]             i_wr_ptr,
  input  logic [DEPTH-1:0]          i_vld,
  input  logic [DEPTH-1:0][AW-1:0]  i_addr,
  input  logic [DEPTH-1:0][DW-1:0]  i_data,
  output logic                      o_hit,
  output logic [DW-1:0]             o_data
);

  logic [PW-1:0] w_idx;

  // Walk oldest to youngest so the entry just behind wr_ptr wins last.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      w_idx = i_wr_ptr - PW'(k);
      if (i_ld_vld && i_vld[w_idx] && (i_addr[w_idx] == i_ld_addr)) begin
        o_hit  = 1'b1;
        o_data = i_data[w_idx];
      end
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-write FIFO between MEM stores and a req/ack data RAM, with load forwarding.
// Store accepted in one cycle unless full (stall); head drained one entry per ack.
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH = SWB_DEPTH,
  parameter int AW    = SWB_AW,
  parameter int DW    = SWB_DW
) (
  input  logic                 clk,
  input  logic                 reset,
  store_write_buffer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][AW-1:0] r_addr;
  logic [DEPTH-1:0][DW-1:0] r_data;
  logic [DEPTH-1:0]         r_vld;
  logic [PW-1:0]            r_wr_ptr;
  logic [PW-1:0]            r_rd_ptr;
  logic [CW-1:0]            r_count;
  swb_state_e               r_state;
  swb_state_e               w_state_nxt;
  logic [CW-1:0]            w_count_nxt;
  logic                     w_full;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_unused;

  assign w_full = (r_count == CW'(DEPTH));
  assign w_push = bus.st_valid & ~w_full;
  assign w_pop  = (r_state == SWB_REQ) & bus.ram_ack;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Request whenever the buffer will be non-empty, so a push into an
  // empty buffer is requested on the very next cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SWB_IDLE: if (w_count_nxt != '0) w_state_nxt = SWB_REQ;
      SWB_REQ:  if (w_pop && (w_count_nxt == '0)) w_state_nxt = SWB_IDLE;
      default:  w_state_nxt = SWB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= SWB_IDLE;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_vld    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_push) begin
        r_wr_ptr        <= r_wr_ptr + PW'(1);
        r_vld[r_wr_ptr] <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr        <= r_rd_ptr + PW'(1);
        r_vld[r_rd_ptr] <= 1'b0;
      end
    end
  end

  // Payload needs no reset; the valid bits and count gate every use of it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= bus.st_addr[AW+1:2];
      r_data[r_wr_ptr] <= bus.st_data;
    end
  end

  swb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW),
    .PW    (PW)
  ) u_fwd_match (
    .i_ld_vld  (bus.ld_valid),
    .i_ld_addr (bus.ld_addr[AW+1:2]),
    .i_wr_ptr  (r_wr_ptr),
    .i_vld     (r_vld),
    .i_addr    (r_addr),
    .i_data    (r_data),
    .o_hit     (bus.ld_hit),
    .o_data    (bus.ld_data)
  );

  assign bus.st_ready  = ~w_full;
  assign bus.ram_req   = (r_state == SWB_REQ);
  assign bus.ram_addr  = r_addr[r_rd_ptr];
  assign bus.ram_wdata = r_data[r_rd_ptr];
  assign bus.count     = r_count;
  assign bus.full      = w_full;
  assign bus.empty     = (r_count == '0);
  assign bus.stall     = bus.st_valid & w_full;

  assign w_unused = ^{bus.st_addr[31:AW+2], bus.st_addr[1:0],
                      bus.ld_addr[31:AW+2], bus.ld_addr[1:0]};

endmodule

// File: tb/tb_store_write_buffer.sv
// Randomized and directed bench for store_write_buffer against a queue-based model.
// Inputs change 1ns after rising edges; outputs are checked on falling edges.
module tb_store_write_buffer;
  import store_write_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 6;
  localparam int DW    = 32;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  store_write_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  ent_t mq[$];       // model contents, oldest first
  ent_t exp_ram[$];  // scoreboard of expected RAM writes
  int   total = 0;
  int   bad = 0;
  int   drained = 0;
  bit   mdl_push = 0;
  bit   chk_wrap = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO that requests whenever it holds data.
  always @(posedge clk or negedge rst_n) begin
    bit p, q;
    if (!rst_n) begin
      mq.delete();
      exp_ram.delete();
      mdl_push = 0;
    end else begin
      q = (mq.size() != 0) && bus.ram_ack;
      p = bus.st_valid && (mq.size() < DEPTH);
      if (q) void'(mq.pop_front());
      if (p) begin
        mq.push_back('{bus.st_addr[AW+1:2], bus.st_data});
        exp_ram.push_back('{bus.st_addr[AW+1:2], bus.st_data});
      end
      mdl_push = p;
    end
  end

  // Monitor
  always @(negedge clk) begin
    int n;
    logic eh;
    logic [DW-1:0] ed;
    ent_t e;
    if (rst_n) begin
      n = mq.size();
      chk("count", 64'(bus.count), 64'(n));
      chk("empty", 64'(bus.empty), 64'(n == 0));
      chk("full", 64'(bus.full), 64'(n == DEPTH));
      chk("st_ready", 64'(bus.st_ready), 64'(n != DEPTH));
      chk("stall", 64'(bus.stall), 64'(bus.st_valid && n == DEPTH));
      chk("ram_req", 64'(bus.ram_req), 64'(n != 0));
      eh = 1'b0;
      ed = '0;
      if (bus.ld_valid) begin
        for (int i = n - 1; i >= 0; i--) begin
          if (!eh && mq[i].a == bus.ld_addr[AW+1:2]) begin
            eh = 1'b1;
            ed = mq[i].d;
          end
        end
      end
      chk("ld_hit", 64'(bus.ld_hit), 64'(eh));
      chk("ld_data", 64'(bus.ld_data), 64'(ed));
      if (bus.ram_req && bus.ram_ack) begin
        if (exp_ram.size() == 0) begin
          chk("ram_unexpected_write", 64'(1), 64'(0));
        end else begin
          e = exp_ram.pop_front();
          chk("ram_addr", 64'(bus.ram_addr), 64'(e.a));
          chk("ram_wdata", 64'(bus.ram_wdata), 64'(e.d));
          drained++;
        end
      end
      if (chk_wrap) chk("wrap_count_le2", 64'(bus.count <= 2), 64'(1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [DW-1:0] d);
    bit ok;
    ok = 0;
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    for (int n = 0; n < 40 && !ok; n++) begin
      tick();
      ok = mdl_push;
    end
    if (!ok) chk("store_timeout", 64'(0), 64'(1));
    bus.st_valid = 1'b0;
  endtask

  task automatic drain();
    bus.ram_ack = 1'b1;
    for (int n = 0; n < 60 && mq.size() != 0; n++) tick();
    chk("drain_done", 64'(mq.size()), 64'(0));
    bus.ram_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] a;
    rst_n        = 1'b0;
    bus.st_valid = 1'b0;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = '0;
    bus.ram_ack  = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_count", 64'(bus.count), 64'(0));
    chk("rst_empty", 64'(bus.empty), 64'(1));
    chk("rst_full", 64'(bus.full), 64'(0));
    chk("rst_st_ready", 64'(bus.st_ready), 64'(1));
    chk("rst_ram_req", 64'(bus.ram_req), 64'(0));
    chk("rst_ld_hit", 64'(bus.ld_hit), 64'(0));
    chk("rst_ld_data", 64'(bus.ld_data), 64'(0));
    chk("rst_stall", 64'(bus.stall), 64'(0));
    bus.ld_valid = 1'b0;
    bus.ram_ack  = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle for 10 cycles
    repeat (10) begin
      @(negedge clk);
      chk("idle_empty", 64'(bus.empty), 64'(1));
      chk("idle_req", 64'(bus.ram_req), 64'(0));
    end
    tick();

    // Single store, ack three cycles after request
    store(32'h10, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s1_req", 64'(bus.ram_req), 64'(1));
      chk("s1_addr", 64'(bus.ram_addr), 64'(4));
      chk("s1_wdata", 64'(bus.ram_wdata), 64'(32'hDEADBEEF));
      tick();
    end
    bus.ram_ack = 1'b1;
    tick();
    bus.ram_ack = 1'b0;
    @(negedge clk);
    chk("s1_count_after", 64'(bus.count), 64'(0));
    chk("s1_req_after", 64'(bus.ram_req), 64'(0));
    tick();

    // Fill and stall
    for (int i = 0; i < 4; i++) store(32'(i * 4), 32'hA000 + 32'(i));
    @(negedge clk);
    chk("fill_full", 64'(bus.full), 64'(1));
    tick();
    bus.st_valid = 1'b1;
    bus.st_addr  = 32'h10;
    bus.st_data  = 32'hA004;
    @(negedge clk);
    chk("fill_stall", 64'(bus.stall), 64'(1));
    chk("fill_st_ready", 64'(bus.st_ready), 64'(0));
    tick();
    bus.ram_ack = 1'b1;
    tick();
    bus.ram_ack = 1'b0;
    tick();
    bus.st_valid = 1'b0;
    @(negedge clk);
    chk("fill_count4", 64'(bus.count), 64'(4));
    tick();
    drain();

    // Forwarding youngest
    store(32'h20, 32'h1111);
    store(32'h24, 32'h2222);
    store(32'h20, 32'h3333);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'h20;
    @(negedge clk);
    chk("fwd_hit20", 64'(bus.ld_hit), 64'(1));
    chk("fwd_data20", 64'(bus.ld_data), 64'(32'h3333));
    tick();
    bus.ld_addr = 32'h28;
    @(negedge clk);
    chk("fwd_hit28", 64'(bus.ld_hit), 64'(0));
    chk("fwd_data28", 64'(bus.ld_data), 64'(0));
    tick();
    bus.ld_valid = 1'b0;
    drain();

    // Wrap-around with ack tied high
    bus.ram_ack = 1'b1;
    chk_wrap = 1;
    base = drained;
    for (int i = 0; i < 10; i++) store(32'h40 + 32'(4 * (i % 5)), $urandom());
    repeat (5) tick();
    chk("wrap_drained10", 64'(drained - base), 64'(10));
    chk_wrap = 0;
    bus.ram_ack = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      a = $urandom();
      a[7:2] = 6'($urandom_range(0, 7));
      bus.st_valid = 1'($urandom_range(0, 1));
      bus.st_addr  = a;
      bus.st_data  = $urandom();
      a = $urandom();
      a[7:2] = 6'($urandom_range(0, 7));
      bus.ld_valid = 1'($urandom_range(0, 1));
      bus.ld_addr  = a;
      bus.ram_ack  = ($urandom_range(0, 2) == 0);
      tick();
    end
    bus.st_valid = 1'b0;
    bus.ld_valid = 1'b0;
    drain();

    // Async reset while a request is outstanding
    store(32'h04, 32'hB001);
    store(32'h08, 32'hB002);
    store(32'h0C, 32'hB003);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 64'(bus.ram_req), 64'(0));
    chk("arst_count", 64'(bus.count), 64'(0));
    chk("arst_empty", 64'(bus.empty), 64'(1));
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.ram_ack = 1'b1;
    base = drained;
    repeat (10) tick();
    chk("arst_nothing_drained", 64'(drained - base), 64'(0));
    bus.ram_ack = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
